// File: rtl/proc_mem_responder_if.sv
// proc_mem_responder_if: fetch/data bus ports, loader port and store-buffer status of the memory responder
interface proc_mem_responder_if #(
    parameter int SB_DEPTH = 4
);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;
    logic [31:0]      imem_addr;
    logic [1:0]       imem_command;
    logic [31:0]      imem_data;
    logic [31:0]      dmem_addr;
    logic [1:0]       dmem_command;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;
    logic             ld_en;
    logic [31:0]      ld_addr;
    logic [31:0]      ld_data;
    logic [CNT_W-1:0] sb_count;
    logic             overflow_err;
    modport master (
        output imem_addr, imem_command, dmem_addr, dmem_command, dmem_wdata,
        output ld_en, ld_addr, ld_data,
        input  imem_data, dmem_rdata, sb_count, overflow_err
    );
    modport slave (
        input  imem_addr, imem_command, dmem_addr, dmem_command, dmem_wdata,
        input  ld_en, ld_addr, ld_data,
        output imem_data, dmem_rdata, sb_count, overflow_err
    );
endinterface

// File: rtl/proc_mem_responder.sv
// proc_mem_responder: word memory with zero-latency fetch/data reads, FIFO store buffer with forwarding, and a priority loader port
module proc_mem_responder #(
    parameter int ADDR_W   = 14,
    parameter int SB_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    proc_mem_responder_if.slave bus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [31:0]       mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] sb_idx_q [SB_DEPTH];
    logic [31:0]       sb_data_q [SB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, slot;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              store_req, full, push, drain, we;
    logic [ADDR_W-1:0] i_idx, d_idx, ld_idx, waddr;
    logic [31:0]       wdata, i_fwd, d_fwd;
    logic              unused_bits;

    assign i_idx  = bus.imem_addr[ADDR_W+1:2];
    assign d_idx  = bus.dmem_addr[ADDR_W+1:2];
    assign ld_idx = bus.ld_addr[ADDR_W+1:2];
    assign unused_bits = ^{bus.imem_addr[31:ADDR_W+2], bus.imem_addr[1:0],
                           bus.dmem_addr[31:ADDR_W+2], bus.dmem_addr[1:0],
                           bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0]};

    // Forwarding: walk entries oldest to youngest so the youngest matching entry wins over the array
    always_comb begin
        i_fwd = mem_q[i_idx];
        d_fwd = mem_q[d_idx];
        slot  = head_q;
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            i_fwd = (CNT_W'(k) < count_q && sb_idx_q[slot] == i_idx) ? sb_data_q[slot] : i_fwd;
            d_fwd = (CNT_W'(k) < count_q && sb_idx_q[slot] == d_idx) ? sb_data_q[slot] : d_fwd;
        end
    end

    assign bus.imem_data    = (bus.imem_command == BUS_LOAD) ? i_fwd : '0;
    assign bus.dmem_rdata   = (bus.dmem_command == BUS_LOAD) ? d_fwd : '0;
    assign bus.sb_count     = count_q;
    assign bus.overflow_err = ovf_q;

    // Push/drain decisions and next pointer/occupancy state; a full buffer still accepts a push when the head drains
    always_comb begin
        store_req = bus.dmem_command == BUS_STORE;
        full      = count_q == CNT_W'(SB_DEPTH);
        drain     = !rst && count_q != '0 && !bus.ld_en;
        push      = !rst && store_req && (!full || drain);
        head_d    = drain ? head_q + 1'b1 : head_q;
        tail_d    = push ? tail_q + 1'b1 : tail_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(drain);
        ovf_d     = ovf_q | (store_req && !push);
        we        = bus.ld_en | drain;
        waddr     = bus.ld_en ? ld_idx : sb_idx_q[head_q];
        wdata     = bus.ld_en ? bus.ld_data : sb_data_q[head_q];
    end

    // Store-buffer control registers; reset discards any pending stores
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Store-buffer entry storage, written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            sb_idx_q[tail_q]  <= d_idx;
            sb_data_q[tail_q] <= bus.dmem_wdata;
        end
    end

    // Single write port into the word array: loader has priority over draining
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
endmodule

// File: tb/tb_proc_mem_responder.sv
// tb_proc_mem_responder: randomized and directed stimulus with a queue-based reference model and a decoupled scoreboard monitor
module tb_proc_mem_responder;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_mem_responder_if #(.SB_DEPTH(4)) bus ();
    proc_mem_responder #(.ADDR_W(14), .SB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { string name; int sel; logic [31:0] exp; } exp_t;
    typedef struct { logic [13:0] idx; logic [31:0] data; } ent_t;

    exp_t        sbq[$];
    ent_t        pend[$];
    logic [31:0] m [16384];
    logic        ovf_m = 1'b0;
    bit          known = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mread(input logic [1:0] cmd, input logic [31:0] a);
        if (cmd != LOAD) return 32'd0;
        for (int k = pend.size() - 1; k >= 0; k--)
            if (pend[k].idx == a[15:2]) return pend[k].data;
        return m[a[15:2]];
    endfunction

    task automatic chk(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [1:0] ic, input logic [31:0] ia,
                         input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dw,
                         input logic le, input logic [31:0] la, input logic [31:0] ldat);
        rst = r;
        bus.imem_command = ic;
        bus.imem_addr    = ia;
        bus.dmem_command = dc;
        bus.dmem_addr    = da;
        bus.dmem_wdata   = dw;
        bus.ld_en        = le;
        bus.ld_addr      = la;
        bus.ld_data      = ldat;
        chk("imem_data", 0, mread(ic, ia));
        chk("dmem_rdata", 1, mread(dc, da));
        if (known) begin
            chk("sb_count", 2, 32'(pend.size()));
            chk("overflow_err", 3, 32'(ovf_m));
        end
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            ovf_m = 1'b0;
            known = 1;
        end else begin
            if (pend.size() > 0 && !bus.ld_en) begin
                e = pend.pop_front();
                m[e.idx] = e.data;
            end
            if (bus.dmem_command == STORE) begin
                if (pend.size() < 4) pend.push_back('{bus.dmem_addr[15:2], bus.dmem_wdata});
                else ovf_m = 1'b1;
            end
        end
        if (bus.ld_en) m[bus.ld_addr[15:2]] = bus.ld_data;
        #1;
    endtask

    task automatic idle(input logic r = 1'b0);
        drive(r, NONE, 0, NONE, 0, 0, 1'b0, 0, 0);
    endtask
    task automatic ldw(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, NONE, 0, NONE, 0, 0, 1'b1, a, d);
    endtask
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic le);
        drive(1'b0, NONE, 0, STORE, a, d, le, 32'h800, 0);
    endtask
    task automatic lo(input logic [31:0] a, input logic le);
        drive(1'b0, LOAD, a, LOAD, a, 0, le, 32'h800, 0);
    endtask

    function automatic logic [31:0] raddr();
        return ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    // Scoreboard monitor: mid-cycle, compare every expectation queued for this cycle
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                act = e.sel == 0 ? bus.imem_data : e.sel == 1 ? bus.dmem_rdata :
                      e.sel == 2 ? 32'(bus.sb_count) : 32'(bus.overflow_err);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s at %0t: got %h expected %h", e.name, $time, act, e.exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] p0, p1, p2, p4;
        #1;
        idle(1'b1); tick();
        idle(1'b1); tick();
        for (int i = 0; i < 256; i++) begin ldw(32'(i) << 2, $urandom); tick(); end
        ldw(32'h800, 0); tick();

        ldw(32'h100, 32'h0050_0093); tick();
        drive(1'b0, LOAD, 32'h100, NONE, 0, 0, 1'b0, 0, 0);
        chk("fetch_0x100", 0, 32'h0050_0093); tick();
        drive(1'b0, NONE, 32'h100, NONE, 0, 0, 1'b0, 0, 0);
        chk("fetch_none", 0, 32'h0); tick();

        st(32'h200, 32'hDEAD_BEEF, 1'b0); tick();
        lo(32'h200, 1'b0);
        chk("fwd_0x200", 1, 32'hDEAD_BEEF); chk("count_one", 2, 32'd1); tick();
        lo(32'h200, 1'b0);
        chk("array_0x200", 1, 32'hDEAD_BEEF); chk("count_zero", 2, 32'd0); tick();

        st(32'h40, 1, 1'b1); tick();
        st(32'h40, 2, 1'b1); tick();
        st(32'h44, 3, 1'b1); tick();
        lo(32'h40, 1'b1); chk("youngest_0x40", 1, 32'd2); chk("youngest_0x40_if", 0, 32'd2); tick();
        lo(32'h44, 1'b1); chk("fwd_0x44", 1, 32'd3); chk("count_three", 2, 32'd3); tick();
        repeat (3) begin idle(); tick(); end
        lo(32'h40, 1'b0); chk("drained_0x40", 1, 32'd2); chk("drained_count", 2, 32'd0); tick();
        lo(32'h44, 1'b0); chk("drained_0x44", 1, 32'd3); tick();

        p4 = m[4];
        for (int i = 0; i < 5; i++) begin st(32'(i) << 2, 32'(i + 1), 1'b1); tick(); end
        lo(32'h10, 1'b1);
        chk("ovf_set", 3, 32'd1); chk("ovf_count", 2, 32'd4); chk("dropped_0x10", 1, p4); tick();
        repeat (6) begin idle(); tick(); end
        idle(); chk("ovf_sticky", 3, 32'd1); chk("ovf_drained", 2, 32'd0); tick();
        idle(1'b1); tick();

        p0 = m[32]; p1 = m[33]; p2 = m[34];
        st(32'h80, 32'hA, 1'b1); tick();
        st(32'h84, 32'hB, 1'b1); tick();
        st(32'h88, 32'hC, 1'b1); tick();
        idle(1'b1); tick();
        lo(32'h80, 1'b0); chk("rst_0x80", 1, p0); chk("rst_count", 2, 32'd0); chk("rst_ovf", 3, 32'd0); tick();
        lo(32'h84, 1'b0); chk("rst_0x84", 1, p1); tick();
        lo(32'h88, 1'b0); chk("rst_0x88", 0, p2); tick();

        st(32'h0001_0004, 32'h55, 1'b0); tick();
        st(32'h0000_0003, 32'h66, 1'b0); tick();
        repeat (3) begin idle(); tick(); end
        lo(32'h4, 1'b0); chk("alias_0x4", 1, 32'h55); tick();
        lo(32'h0, 1'b0); chk("alias_0x0", 1, 32'h66); tick();

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, LOAD, raddr(), STORE, raddr(), $urandom, 1'b0, 0, 0); tick();
        end
        idle(); chk("wrap_no_ovf", 3, 32'd0); tick();

        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)), raddr(),
                  2'($urandom_range(0, 3)), raddr(), $urandom,
                  $urandom_range(0, 5) == 0, raddr(), $urandom);
            tick();
        end
        repeat (6) begin idle(); tick(); end
        for (int i = 0; i < 32; i++) begin lo(32'(i) << 2, 1'b0); tick(); end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
